// File: rtl/stream_pkg.sv
// Shared types and default sizing for the XOR-bitmap to pixel-stream converter.
package stream_pkg;

    localparam int DEF_BLK_W    = 16;
    localparam int DEF_BLK_H    = 16;
    localparam int DEF_DECIMATE = 2;
    localparam int DEF_LANES    = 1;
    localparam int DEF_CONF_W   = 8;
    localparam int DEF_COORD_W  = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_e;

    typedef struct packed {
        logic [DEF_BLK_H-1:0][DEF_BLK_W-1:0] bitmap;
        logic [DEF_CONF_W-1:0]               conf;
        logic [DEF_COORD_W-1:0]              coord;
    } blk_rec_t;

    // A block of a single beat still needs a 1-bit counter.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/blk_decimator.sv
// Picks the LANES subsampled bits of one output beat out of a block bitmap.
module blk_decimator #(
    parameter int BLK_W    = 16,
    parameter int BLK_H    = 16,
    parameter int DECIMATE = 2,
    parameter int LANES    = 1,
    parameter int CNT_W    = 6
) (
    input  logic [BLK_H-1:0][BLK_W-1:0] bitmap,
    input  logic [CNT_W-1:0]            row_idx,
    input  logic [CNT_W-1:0]            beat_idx,
    output logic [LANES-1:0]            lanes
);

    localparam int RW = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam int CW = (BLK_W > 1) ? $clog2(BLK_W) : 1;

    logic [RW-1:0] row_sel;

    always_comb begin
        logic [CW-1:0] col_sel;
        row_sel = RW'(int'(row_idx) * DECIMATE);
        lanes   = '0;
        for (int k = 0; k < LANES; k++) begin
            col_sel  = CW'((int'(beat_idx) * LANES + k) * DECIMATE);
            lanes[k] = bitmap[row_sel][col_sel];
        end
    end

endmodule

// File: rtl/xors_to_stream_wide.sv
// Double-buffered converter from whole XOR-bitmap blocks to a decimated,
// LANES-wide pixel stream carrying the block's confidence and disparity.
module xors_to_stream_wide
    import stream_pkg::*;
#(
    parameter int BLK_W    = DEF_BLK_W,
    parameter int BLK_H    = DEF_BLK_H,
    parameter int DECIMATE = DEF_DECIMATE,
    parameter int LANES    = DEF_LANES,
    parameter int CONF_W   = DEF_CONF_W,
    parameter int COORD_W  = DEF_COORD_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BLK_H-1:0][BLK_W-1:0]   xors_in,
    input  logic                          xors_valid,
    output logic                          xors_ready,
    input  logic [CONF_W-1:0]             confidence,
    input  logic [COORD_W-1:0]            min_coords,
    output logic [LANES-1:0]              pix_stream_data,
    output logic                          pix_stream_valid,
    input  logic                          pix_stream_ready,
    output logic [CONF_W-1:0]             conf_out,
    output logic [COORD_W-1:0]            disp_out,
    output logic                          row_first,
    output logic                          blk_last
);

    localparam int ROWS  = BLK_H / DECIMATE;
    localparam int BPR   = (BLK_W / DECIMATE) / LANES;
    localparam int BEATS = ROWS * BPR;
    localparam int CNT_W = cnt_width(BEATS);

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(BPR - 1);

    typedef struct packed {
        logic [BLK_H-1:0][BLK_W-1:0] bitmap;
        logic [CONF_W-1:0]           conf;
        logic [COORD_W-1:0]          coord;
    } blk_t;

    stream_state_e    state_q, state_d;
    blk_t             active_q, active_d;
    blk_t             pending_q, pending_d;
    logic             pending_full_q, pending_full_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;

    blk_t             in_blk;
    logic             accept;
    logic             take;
    logic             at_last;
    logic [LANES-1:0] lane_bits;

    assign in_blk = '{bitmap: xors_in, conf: confidence, coord: min_coords};

    // Readiness is masked while reset is held so no block is offered a slot.
    assign xors_ready       = reset && !pending_full_q;
    assign pix_stream_valid = (state_q == ST_STREAM);
    assign accept           = xors_valid && xors_ready;
    assign take             = pix_stream_valid && pix_stream_ready;
    assign at_last          = (row_q == LAST_ROW) && (col_q == LAST_COL);

    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        row_d          = row_q;
        col_d          = col_q;

        if (take) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // Finishing a block hands over to PENDING, else to a block offered on this very edge.
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    active_d = in_blk;
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (take && at_last) begin
                    if (pending_full_q) begin
                        active_d       = pending_q;
                        pending_full_d = 1'b0;
                    end else if (accept) begin
                        active_d = in_blk;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept) begin
                    pending_d      = in_blk;
                    pending_full_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            row_q          <= '0;
            col_q          <= '0;
        end else begin
            state_q        <= state_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            row_q          <= row_d;
            col_q          <= col_d;
        end
    end

    blk_decimator #(
        .BLK_W    (BLK_W),
        .BLK_H    (BLK_H),
        .DECIMATE (DECIMATE),
        .LANES    (LANES),
        .CNT_W    (CNT_W)
    ) u_decimator (
        .bitmap   (active_q.bitmap),
        .row_idx  (row_q),
        .beat_idx (col_q),
        .lanes    (lane_bits)
    );

    assign pix_stream_data = lane_bits;
    assign conf_out        = active_q.conf;
    assign disp_out        = active_q.coord;
    assign row_first       = pix_stream_valid && (col_q == '0);
    assign blk_last        = pix_stream_valid && at_last;

endmodule

// File: tb/tb_xors_to_stream_wide.sv
// Self-checking bench: a wide (LANES=4, DECIMATE=2) and a full-resolution
// (LANES=1, DECIMATE=1) converter checked against a queue of expected beats.
module tb_xors_to_stream_wide;

    localparam int BW = 16;
    localparam int BH = 16;

    typedef logic [BH-1:0][BW-1:0] bmp_t;

    typedef struct {
        logic [3:0] data;
        logic       first;
        logic       last;
        logic [7:0] conf;
        logic [7:0] disp;
    } beat_t;

    typedef struct {
        bmp_t       bmp;
        logic [7:0] conf;
        logic [7:0] disp;
    } tb_blk_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    bmp_t       xors_in;
    logic [7:0] confidence;
    logic [7:0] min_coords;

    logic       valid_a, pready_a, xready_a, pvalid_a, rf_a, bl_a;
    logic [3:0] data_a;
    logic [7:0] conf_a, disp_a;

    logic       valid_b, pready_b, xready_b, pvalid_b, rf_b, bl_b;
    logic [0:0] data_b;
    logic [7:0] conf_b, disp_b;

    int      total;
    int      bad;
    bit      sel;
    bit      mon_en;
    int      ready_mode;
    int      accepted;
    int      completed;
    int      beats_taken;
    beat_t   sb[$];
    tb_blk_t offers[$];

    always #5 clk = ~clk;

    xors_to_stream_wide #(
        .LANES (4)
    ) dut_a (
        .clk              (clk),
        .reset            (reset),
        .xors_in          (xors_in),
        .xors_valid       (valid_a),
        .xors_ready       (xready_a),
        .confidence       (confidence),
        .min_coords       (min_coords),
        .pix_stream_data  (data_a),
        .pix_stream_valid (pvalid_a),
        .pix_stream_ready (pready_a),
        .conf_out         (conf_a),
        .disp_out         (disp_a),
        .row_first        (rf_a),
        .blk_last         (bl_a)
    );

    xors_to_stream_wide #(
        .DECIMATE (1),
        .LANES    (1)
    ) dut_b (
        .clk              (clk),
        .reset            (reset),
        .xors_in          (xors_in),
        .xors_valid       (valid_b),
        .xors_ready       (xready_b),
        .confidence       (confidence),
        .min_coords       (min_coords),
        .pix_stream_data  (data_b),
        .pix_stream_valid (pvalid_b),
        .pix_stream_ready (pready_b),
        .conf_out         (conf_b),
        .disp_out         (disp_b),
        .row_first        (rf_b),
        .blk_last         (bl_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic tb_blk_t make_blk(input int pattern, input logic [7:0] conf, input logic [7:0] disp);
        tb_blk_t b;
        for (int r = 0; r < BH; r++) begin
            for (int c = 0; c < BW; c++) begin
                case (pattern)
                    0:       b.bmp[r][c] = (((r + c) % 2) == 1);
                    1:       b.bmp[r][c] = (r == c);
                    default: b.bmp[r][c] = 1'($urandom_range(0, 1));
                endcase
            end
        end
        b.conf = conf;
        b.disp = disp;
        return b;
    endfunction

    // Beats of a block straight from the subsampling rule: every dec-th row,
    // every dec-th column, lanes columns per beat, lowest column in lane 0.
    function automatic void push_beats(input tb_blk_t b);
        int    lanes;
        int    dec;
        int    rows;
        int    per_row;
        beat_t e;
        lanes   = sel ? 1 : 4;
        dec     = sel ? 1 : 2;
        rows    = BH / dec;
        per_row = (BW / dec) / lanes;
        for (int r = 0; r < rows; r++) begin
            for (int j = 0; j < per_row; j++) begin
                e.data = '0;
                for (int k = 0; k < lanes; k++) begin
                    e.data[k] = b.bmp[r * dec][(j * lanes + k) * dec];
                end
                e.first = (j == 0);
                e.last  = (r == rows - 1) && (j == per_row - 1);
                e.conf  = b.conf;
                e.disp  = b.disp;
                sb.push_back(e);
            end
        end
    endfunction

    // One clock: note any handshake, update the model, check readiness, drive the next inputs.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            bit      acc;
            bit      pr;
            tb_blk_t b;
            @(negedge clk);
            acc = sel ? (valid_b && xready_b) : (valid_a && xready_a);
            @(posedge clk);
            #1;
            if (acc) begin
                b = offers.pop_front();
                push_beats(b);
                accepted++;
            end
            checkOutput("xors_ready", 32'(sel ? xready_b : xready_a), 32'((accepted - completed) < 2));
            valid_a = 1'b0;
            valid_b = 1'b0;
            if (offers.size() != 0) begin
                xors_in    = offers[0].bmp;
                confidence = offers[0].conf;
                min_coords = offers[0].disp;
                if (sel) valid_b = 1'b1;
                else     valid_a = 1'b1;
            end
            pr = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            pready_a = sel ? 1'b0 : pr;
            pready_b = sel ? pr : 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (sb.size() != 0 || offers.size() != 0); i++) begin
            applyStimulus(1);
        end
        checkOutput("drain_left", 32'(sb.size() + offers.size()), 32'd0);
    endtask

    task automatic reset_dut();
        reset    = 1'b0;
        offers.delete();
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        pready_a = 1'b0;
        pready_b = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        accepted  = 0;
        completed = 0;
        checkOutput("rst_valid_a",  32'(pvalid_a), 32'd0);
        checkOutput("rst_first_a",  32'(rf_a),     32'd0);
        checkOutput("rst_last_a",   32'(bl_a),     32'd0);
        checkOutput("rst_xready_a", 32'(xready_a), 32'd0);
        checkOutput("rst_data_a",   32'(data_a),   32'd0);
        checkOutput("rst_conf_a",   32'(conf_a),   32'd0);
        checkOutput("rst_disp_a",   32'(disp_a),   32'd0);
        checkOutput("rst_valid_b",  32'(pvalid_b), 32'd0);
        checkOutput("rst_xready_b", 32'(xready_b), 32'd0);
        checkOutput("rst_data_b",   32'(data_b),   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset_a", 32'(xready_a), 32'd1);
        checkOutput("ready_after_reset_b", 32'(xready_b), 32'd1);
    endtask

    // Every valid beat must be the head of the expected queue, held there until taken.
    always @(negedge clk) begin
        logic       v, r, rf, bl;
        logic [3:0] d;
        logic [7:0] c, p;
        if (mon_en) begin
            if (sel) begin
                v = pvalid_b; r = pready_b; rf = rf_b; bl = bl_b;
                d = {3'b000, data_b}; c = conf_b; p = disp_b;
            end else begin
                v = pvalid_a; r = pready_a; rf = rf_a; bl = bl_a;
                d = data_a; c = conf_a; p = disp_a;
            end
            checkOutput("pix_valid", 32'(v), 32'(sb.size() != 0));
            if (v === 1'b1 && sb.size() != 0) begin
                checkOutput("pix_data",  32'(d),  32'(sb[0].data));
                checkOutput("row_first", 32'(rf), 32'(sb[0].first));
                checkOutput("blk_last",  32'(bl), 32'(sb[0].last));
                checkOutput("conf_out",  32'(c),  32'(sb[0].conf));
                checkOutput("disp_out",  32'(p),  32'(sb[0].disp));
                if (r) begin
                    if (sb[0].last) completed++;
                    void'(sb.pop_front());
                    beats_taken++;
                end
            end
        end
    end

    initial begin
        int bt0;
        total       = 0;
        bad         = 0;
        sel         = 1'b0;
        mon_en      = 1'b0;
        ready_mode  = 1;
        accepted    = 0;
        completed   = 0;
        beats_taken = 0;
        valid_a     = 1'b0;
        valid_b     = 1'b0;
        pready_a    = 1'b0;
        pready_b    = 1'b0;
        xors_in     = '0;
        confidence  = '0;
        min_coords  = '0;

        reset_dut();
        mon_en = 1'b1;

        $display("[TB] checkerboard block, ready high");
        ready_mode = 1;
        offers.push_back(make_blk(0, 8'h11, 8'h22));
        drain(200);

        $display("[TB] back-to-back blocks, confidence 3 then 7");
        offers.push_back(make_blk(2, 8'd3, 8'h40));
        offers.push_back(make_blk(2, 8'd7, 8'h41));
        drain(200);

        $display("[TB] identity block with ready toggling");
        ready_mode = 2;
        offers.push_back(make_blk(1, 8'h5a, 8'h09));
        drain(300);

        $display("[TB] three offers while downstream stalls");
        ready_mode = 0;
        offers.push_back(make_blk(2, 8'h01, 8'h10));
        offers.push_back(make_blk(2, 8'h02, 8'h20));
        offers.push_back(make_blk(2, 8'h03, 8'h30));
        applyStimulus(20);
        checkOutput("third_held", 32'(offers.size()), 32'd1);
        checkOutput("blocks_held", 32'(accepted - completed), 32'd2);
        ready_mode = 1;
        drain(300);

        $display("[TB] reset in the middle of a block");
        offers.push_back(make_blk(2, 8'h99, 8'h77));
        bt0 = beats_taken;
        for (int i = 0; i < 100 && beats_taken < bt0 + 5; i++) begin
            applyStimulus(1);
        end
        checkOutput("beats_before_reset", 32'(beats_taken - bt0), 32'd5);
        reset_dut();
        applyStimulus(5);
        offers.push_back(make_blk(2, 8'h44, 8'h55));
        drain(200);

        $display("[TB] random blocks with random ready");
        ready_mode = 2;
        for (int i = 0; i < 4; i++) begin
            offers.push_back(make_blk(2, 8'($urandom), 8'($urandom)));
        end
        drain(1000);

        $display("[TB] full-resolution single-lane instance");
        sel        = 1'b1;
        ready_mode = 2;
        for (int i = 0; i < 2; i++) begin
            offers.push_back(make_blk(2, 8'($urandom), 8'($urandom)));
        end
        drain(4000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
